// File: rtl/cosim_constants_pkg.sv
// Architectural widths shared by the cosim commit-log types.
package cosim_constants_pkg;
  localparam int unsigned XREG_W         = 32;
  localparam int unsigned FREG_W         = 64;
  localparam int unsigned REG_KEY_ID_W   = 5;
  localparam int unsigned REG_KEY_TYPE_W = 2;
endpackage

// File: rtl/cosim_pkg.sv
// Commit-log item and record types exchanged between the RTL collector and
// the cosim checker.
package cosim_pkg;
  import cosim_constants_pkg::*;

  localparam int unsigned CommitLogEntries = 16;

  typedef enum logic [REG_KEY_TYPE_W-1:0] {
    REG_XREG = 2'd0,
    REG_FREG = 2'd1,
    REG_CSR  = 2'd2,
    REG_VREG = 2'd3
  } reg_type_e;

  typedef struct packed {
    logic [REG_KEY_ID_W-1:0] id;
    reg_type_e               rtype;
  } reg_key_t;

  typedef logic [FREG_W-1:0] reg_t;

  typedef struct packed {
    reg_key_t key;
    reg_t     value;
  } commit_log_reg_item_t;

  typedef struct packed {
    logic [XREG_W-1:0] addr;
    logic [XREG_W-1:0] paddr;
    logic [XREG_W-1:0] wdata;
    logic [7:0]        len;
  } commit_log_mem_item_t;

  typedef struct packed {
    logic [XREG_W-1:0]                                pc;
    logic [31:0]                                      priv;
    logic [31:0]                                      proc_id;
    commit_log_reg_item_t [CommitLogEntries-1:0]      reg_list;
    commit_log_mem_item_t [CommitLogEntries-1:0]      mem_rd_list;
    commit_log_mem_item_t [CommitLogEntries-1:0]      mem_wr_list;
    logic [31:0]                                      reg_cnt;
    logic [31:0]                                      mem_rd_cnt;
    logic [31:0]                                      mem_wr_cnt;
  } commit_record_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } hold_state_e;
endpackage

// File: rtl/cosim_log_list.sv
// Append buffer for one commit-log list: saturating count, sticky overflow,
// and a snapshot view that already includes this cycle's append.
module cosim_log_list #(
  parameter type         item_t = logic [7:0],
  parameter int unsigned Depth  = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                append_i,
  input  item_t               item_i,
  input  logic                clear_i,
  output item_t [Depth-1:0]   snap_list_o,
  output logic  [31:0]        snap_cnt_o,
  output logic                overflow_o
);
  localparam int unsigned CntW = $clog2(Depth + 1);

  item_t [Depth-1:0] list_r;
  item_t [Depth-1:0] list_s;
  logic  [CntW-1:0]  cnt_r;
  logic  [CntW-1:0]  cnt_s;
  logic              overflow_r;
  logic              drop_s;

  // Merge the pending append into the stored list; a full list drops it.
  always_comb begin
    list_s = list_r;
    cnt_s  = cnt_r;
    drop_s = 1'b0;
    if (append_i) begin
      if (cnt_r == CntW'(Depth)) begin
        drop_s = 1'b1;
      end else begin
        for (int unsigned i = 0; i < Depth; i++) begin
          if (cnt_r == CntW'(i)) begin
            list_s[i] = item_i;
          end else begin
            list_s[i] = list_s[i];
          end
        end
        cnt_s = cnt_r + CntW'(1);
      end
    end else begin
      drop_s = 1'b0;
    end
  end

  // Stored list and count advance only on accepted cycles; retire empties the count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      list_r     <= '0;
      cnt_r      <= {CntW{1'b0}};
      overflow_r <= 1'b0;
    end else if (en_i) begin
      list_r <= list_s;
      cnt_r  <= clear_i ? {CntW{1'b0}} : cnt_s;
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign snap_list_o = list_s;
  assign snap_cnt_o  = 32'(cnt_s);
  assign overflow_o  = overflow_r;
endmodule

// File: rtl/cosim_commit_collector.sv
// Collects per-instruction register/memory events and presents one commit
// record per retired instruction through a single holding register.
module cosim_commit_collector
  import cosim_constants_pkg::*;
  import cosim_pkg::*;
#(
  parameter int unsigned ProcId = 32'd0
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  output logic                                        ready_o,
  input  logic                                        reg_wr_valid_i,
  input  commit_log_reg_item_t                        reg_wr_item_i,
  input  logic                                        mem_rd_valid_i,
  input  commit_log_mem_item_t                        mem_rd_item_i,
  input  logic                                        mem_wr_valid_i,
  input  commit_log_mem_item_t                        mem_wr_item_i,
  input  logic                                        retire_valid_i,
  input  logic [XREG_W-1:0]                           retire_pc_i,
  input  logic [1:0]                                  retire_priv_i,
  output logic                                        rec_valid_o,
  input  logic                                        rec_ready_i,
  output logic [XREG_W-1:0]                           rec_pc_o,
  output logic [31:0]                                 rec_priv_o,
  output logic [31:0]                                 rec_proc_id_o,
  output commit_log_reg_item_t [CommitLogEntries-1:0] rec_reg_o,
  output logic [31:0]                                 rec_reg_cnt_o,
  output commit_log_mem_item_t [CommitLogEntries-1:0] rec_mem_rd_o,
  output logic [31:0]                                 rec_mem_rd_cnt_o,
  output commit_log_mem_item_t [CommitLogEntries-1:0] rec_mem_wr_o,
  output logic [31:0]                                 rec_mem_wr_cnt_o,
  output logic                                        overflow_o
);
  hold_state_e    state_r;
  commit_record_t rec_r;
  commit_record_t record_s;
  logic           ready_s;
  logic           reg_ovf_s;
  logic           rd_ovf_s;
  logic           wr_ovf_s;

  commit_log_reg_item_t [CommitLogEntries-1:0] reg_snap_s;
  commit_log_mem_item_t [CommitLogEntries-1:0] rd_snap_s;
  commit_log_mem_item_t [CommitLogEntries-1:0] wr_snap_s;
  logic [31:0] reg_cnt_s;
  logic [31:0] rd_cnt_s;
  logic [31:0] wr_cnt_s;

  // Free holding slot, or the checker drains it this cycle.
  assign ready_s = (state_r == ST_EMPTY) | rec_ready_i;

  cosim_log_list #(.item_t(commit_log_reg_item_t), .Depth(CommitLogEntries)) u_reg_list (
    .clk_i, .rst_ni, .en_i(ready_s), .append_i(reg_wr_valid_i), .item_i(reg_wr_item_i),
    .clear_i(retire_valid_i), .snap_list_o(reg_snap_s), .snap_cnt_o(reg_cnt_s), .overflow_o(reg_ovf_s)
  );

  cosim_log_list #(.item_t(commit_log_mem_item_t), .Depth(CommitLogEntries)) u_mem_rd_list (
    .clk_i, .rst_ni, .en_i(ready_s), .append_i(mem_rd_valid_i), .item_i(mem_rd_item_i),
    .clear_i(retire_valid_i), .snap_list_o(rd_snap_s), .snap_cnt_o(rd_cnt_s), .overflow_o(rd_ovf_s)
  );

  cosim_log_list #(.item_t(commit_log_mem_item_t), .Depth(CommitLogEntries)) u_mem_wr_list (
    .clk_i, .rst_ni, .en_i(ready_s), .append_i(mem_wr_valid_i), .item_i(mem_wr_item_i),
    .clear_i(retire_valid_i), .snap_list_o(wr_snap_s), .snap_cnt_o(wr_cnt_s), .overflow_o(wr_ovf_s)
  );

  // Assemble the record for an instruction retiring this cycle.
  always_comb begin
    record_s             = '0;
    record_s.pc          = retire_pc_i;
    record_s.priv        = {30'd0, retire_priv_i};
    record_s.proc_id     = 32'(ProcId);
    record_s.reg_list    = reg_snap_s;
    record_s.mem_rd_list = rd_snap_s;
    record_s.mem_wr_list = wr_snap_s;
    record_s.reg_cnt     = reg_cnt_s;
    record_s.mem_rd_cnt  = rd_cnt_s;
    record_s.mem_wr_cnt  = wr_cnt_s;
  end

  // Holding register: load on retire, drain on handshake, hold otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_EMPTY;
      rec_r   <= '0;
    end else if (ready_s) begin
      if (retire_valid_i) begin
        state_r <= ST_FULL;
        rec_r   <= record_s;
      end else begin
        state_r <= ST_EMPTY;
      end
    end
  end

  assign ready_o          = ready_s;
  assign rec_valid_o      = (state_r == ST_FULL);
  assign rec_pc_o         = rec_r.pc;
  assign rec_priv_o       = rec_r.priv;
  assign rec_proc_id_o    = rec_r.proc_id;
  assign rec_reg_o        = rec_r.reg_list;
  assign rec_reg_cnt_o    = rec_r.reg_cnt;
  assign rec_mem_rd_o     = rec_r.mem_rd_list;
  assign rec_mem_rd_cnt_o = rec_r.mem_rd_cnt;
  assign rec_mem_wr_o     = rec_r.mem_wr_list;
  assign rec_mem_wr_cnt_o = rec_r.mem_wr_cnt;
  assign overflow_o       = reg_ovf_s | rd_ovf_s | wr_ovf_s;
endmodule

// File: tb/tb_cosim_commit_collector.sv
// Directed bench for cosim_commit_collector: vector table plus hand-written
// backpressure, overflow and reset sequences.
module tb_cosim_commit_collector;
  import cosim_constants_pkg::*;
  import cosim_pkg::*;

  logic clk;
  logic rst_ni;
  logic ready_o;
  logic reg_wr_valid_i;
  commit_log_reg_item_t reg_wr_item_i;
  logic mem_rd_valid_i;
  commit_log_mem_item_t mem_rd_item_i;
  logic mem_wr_valid_i;
  commit_log_mem_item_t mem_wr_item_i;
  logic retire_valid_i;
  logic [XREG_W-1:0] retire_pc_i;
  logic [1:0] retire_priv_i;
  logic rec_valid_o;
  logic rec_ready_i;
  logic [XREG_W-1:0] rec_pc_o;
  logic [31:0] rec_priv_o;
  logic [31:0] rec_proc_id_o;
  commit_log_reg_item_t [CommitLogEntries-1:0] rec_reg_o;
  logic [31:0] rec_reg_cnt_o;
  commit_log_mem_item_t [CommitLogEntries-1:0] rec_mem_rd_o;
  logic [31:0] rec_mem_rd_cnt_o;
  commit_log_mem_item_t [CommitLogEntries-1:0] rec_mem_wr_o;
  logic [31:0] rec_mem_wr_cnt_o;
  logic overflow_o;

  int passed = 0;
  int total  = 0;

  cosim_commit_collector #(.ProcId(32'd0)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .ready_o(ready_o),
    .reg_wr_valid_i(reg_wr_valid_i), .reg_wr_item_i(reg_wr_item_i),
    .mem_rd_valid_i(mem_rd_valid_i), .mem_rd_item_i(mem_rd_item_i),
    .mem_wr_valid_i(mem_wr_valid_i), .mem_wr_item_i(mem_wr_item_i),
    .retire_valid_i(retire_valid_i), .retire_pc_i(retire_pc_i), .retire_priv_i(retire_priv_i),
    .rec_valid_o(rec_valid_o), .rec_ready_i(rec_ready_i),
    .rec_pc_o(rec_pc_o), .rec_priv_o(rec_priv_o), .rec_proc_id_o(rec_proc_id_o),
    .rec_reg_o(rec_reg_o), .rec_reg_cnt_o(rec_reg_cnt_o),
    .rec_mem_rd_o(rec_mem_rd_o), .rec_mem_rd_cnt_o(rec_mem_rd_cnt_o),
    .rec_mem_wr_o(rec_mem_wr_o), .rec_mem_wr_cnt_o(rec_mem_wr_cnt_o),
    .overflow_o(overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        reg_v;
    logic [4:0]  reg_id;
    logic [63:0] reg_val;
    logic        rd_v;
    logic        wr_v;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ret;
    logic [31:0] pc;
    logic [1:0]  priv;
    logic        rdy;
    logic        e_ready;
    logic        e_valid;
    logic [31:0] e_reg;
    logic [31:0] e_rd;
    logic [31:0] e_wr;
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mk(input logic reg_v, input logic [4:0] reg_id, input logic [63:0] reg_val,
                              input logic rd_v, input logic wr_v, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic ret, input logic [31:0] pc,
                              input logic [1:0] priv, input logic e_valid, input logic [31:0] e_reg,
                              input logic [31:0] e_rd, input logic [31:0] e_wr);
    vec_t v;
    v.reg_v = reg_v; v.reg_id = reg_id; v.reg_val = reg_val;
    v.rd_v = rd_v; v.wr_v = wr_v; v.addr = addr; v.wdata = wdata;
    v.ret = ret; v.pc = pc; v.priv = priv; v.rdy = 1'b1; v.e_ready = 1'b1;
    v.e_valid = e_valid; v.e_reg = e_reg; v.e_rd = e_rd; v.e_wr = e_wr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic reg_v, input logic [4:0] id, input logic [63:0] val,
                       input logic rd_v, input logic wr_v, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic ret, input logic [31:0] pc,
                       input logic [1:0] priv, input logic rdy);
    reg_wr_valid_i            = reg_v;
    reg_wr_item_i.key.id      = id;
    reg_wr_item_i.key.rtype   = REG_XREG;
    reg_wr_item_i.value       = val;
    mem_rd_valid_i            = rd_v;
    mem_rd_item_i.addr        = addr;
    mem_rd_item_i.paddr       = addr;
    mem_rd_item_i.wdata       = 32'd0;
    mem_rd_item_i.len         = 8'd4;
    mem_wr_valid_i            = wr_v;
    mem_wr_item_i.addr        = addr;
    mem_wr_item_i.paddr       = addr;
    mem_wr_item_i.wdata       = wdata;
    mem_wr_item_i.len         = 8'd4;
    retire_valid_i            = ret;
    retire_pc_i               = pc;
    retire_priv_i             = priv;
    rec_ready_i               = rdy;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 2'd0, rdy);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rec(input string tag, input logic [31:0] e_reg, input logic [31:0] e_rd,
                         input logic [31:0] e_wr, input logic [31:0] e_pc, input logic [31:0] e_priv);
    chk({tag, ".valid"}, 64'(rec_valid_o), 64'd1);
    chk({tag, ".reg_cnt"}, 64'(rec_reg_cnt_o), 64'(e_reg));
    chk({tag, ".rd_cnt"}, 64'(rec_mem_rd_cnt_o), 64'(e_rd));
    chk({tag, ".wr_cnt"}, 64'(rec_mem_wr_cnt_o), 64'(e_wr));
    chk({tag, ".pc"}, 64'(rec_pc_o), 64'(e_pc));
    chk({tag, ".priv"}, 64'(rec_priv_o), 64'(e_priv));
    chk({tag, ".proc_id"}, 64'(rec_proc_id_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench exceeded its time budget");
    $fatal(1);
  end

  initial begin
    vecs[0] = mk(1'b1, 5'd5, 64'h2A, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h8000_0000, 2'd3,
                 1'b1, 32'd1, 32'd0, 32'd0);
    vecs[1] = mk(1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 2'd0,
                 1'b0, 32'd0, 32'd0, 32'd0);
    vecs[2] = mk(1'b0, 5'd0, 64'd0, 1'b0, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 1'b0, 32'd0, 2'd0,
                 1'b0, 32'd0, 32'd0, 32'd0);
    vecs[3] = mk(1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h8000_0004, 2'd3,
                 1'b1, 32'd0, 32'd0, 32'd1);
    vecs[4] = mk(1'b1, 5'd7, 64'h1234, 1'b1, 1'b0, 32'h8000_2000, 32'd0, 1'b1, 32'h8000_0008, 2'd0,
                 1'b1, 32'd1, 32'd1, 32'd0);
    vecs[5] = mk(1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h8000_000C, 2'd1,
                 1'b1, 32'd0, 32'd0, 32'd0);
    vecs[6] = mk(1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 2'd0,
                 1'b0, 32'd0, 32'd0, 32'd0);

    // Reset and idle
    rst_ni = 1'b0;
    idle(1'b1);
    #12;
    chk("rst.valid", 64'(rec_valid_o), 64'd0);
    chk("rst.reg_cnt", 64'(rec_reg_cnt_o), 64'd0);
    chk("rst.rd_cnt", 64'(rec_mem_rd_cnt_o), 64'd0);
    chk("rst.wr_cnt", 64'(rec_mem_wr_cnt_o), 64'd0);
    chk("rst.overflow", 64'(overflow_o), 64'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    idle(1'b0);
    cycle();
    chk("idle.ready", 64'(ready_o), 64'd1);
    chk("idle.valid", 64'(rec_valid_o), 64'd0);

    // Table: ADDI, store over two cycles, back-to-back retires, empty retire
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].reg_v, vecs[i].reg_id, vecs[i].reg_val, vecs[i].rd_v, vecs[i].wr_v,
            vecs[i].addr, vecs[i].wdata, vecs[i].ret, vecs[i].pc, vecs[i].priv, vecs[i].rdy);
      #1;
      chk($sformatf("v%0d.ready", i), 64'(ready_o), 64'(vecs[i].e_ready));
      cycle();
      chk($sformatf("v%0d.valid", i), 64'(rec_valid_o), 64'(vecs[i].e_valid));
      if (vecs[i].e_valid) begin
        chk_rec($sformatf("v%0d", i), vecs[i].e_reg, vecs[i].e_rd, vecs[i].e_wr, vecs[i].pc,
                {30'd0, vecs[i].priv});
        if (vecs[i].e_reg != 32'd0) begin
          chk($sformatf("v%0d.reg0.id", i), 64'(rec_reg_o[0].key.id), 64'(vecs[i].reg_id));
          chk($sformatf("v%0d.reg0.type", i), 64'(rec_reg_o[0].key.rtype), 64'd0);
          chk($sformatf("v%0d.reg0.val", i), rec_reg_o[0].value, vecs[i].reg_val);
        end
        if (vecs[i].e_rd != 32'd0) begin
          chk($sformatf("v%0d.rd0.addr", i), 64'(rec_mem_rd_o[0].addr), 64'(vecs[i].addr));
        end
        if (vecs[i].e_wr != 32'd0) begin
          chk($sformatf("v%0d.wr0.addr", i), 64'(rec_mem_wr_o[0].addr), 64'h8000_1000);
          chk($sformatf("v%0d.wr0.wdata", i), 64'(rec_mem_wr_o[0].wdata), 64'hDEAD_BEEF);
          chk($sformatf("v%0d.wr0.len", i), 64'(rec_mem_wr_o[0].len), 64'd4);
        end
      end
    end

    // Backpressure: record A held for 3 cycles while B waits on the inputs
    drive(1'b1, 5'd1, 64'h11, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'hA0, 2'd3, 1'b0);
    #1;
    chk("bp.ready_a", 64'(ready_o), 64'd1);
    cycle();
    drive(1'b1, 5'd2, 64'h22, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'hB0, 2'd3, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp.stall%0d.ready", k), 64'(ready_o), 64'd0);
      chk_rec($sformatf("bp.stall%0d", k), 32'd1, 32'd0, 32'd0, 32'hA0, 32'd3);
      chk($sformatf("bp.stall%0d.val", k), rec_reg_o[0].value, 64'h11);
      cycle();
    end
    rec_ready_i = 1'b1;
    #1;
    chk("bp.ready_b", 64'(ready_o), 64'd1);
    cycle();
    chk_rec("bp.b", 32'd1, 32'd0, 32'd0, 32'hB0, 32'd3);
    chk("bp.b.val", rec_reg_o[0].value, 64'h22);
    idle(1'b1);
    cycle();
    chk("bp.drain", 64'(rec_valid_o), 64'd0);

    // Overflow: 17 register writes, the last one dropped
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 5'(i), 64'h100 + 64'(i), 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 2'd0, 1'b1);
      cycle();
      if (i == 15) chk("ovf.before", 64'(overflow_o), 64'd0);
    end
    chk("ovf.set", 64'(overflow_o), 64'd1);
    drive(1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'hC0, 2'd3, 1'b1);
    cycle();
    chk_rec("ovf.rec", 32'd16, 32'd0, 32'd0, 32'hC0, 32'd3);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovf.entry%0d", i), rec_reg_o[i].value, 64'h100 + 64'(i));
    end
    idle(1'b1);
    repeat (3) cycle();
    chk("ovf.sticky", 64'(overflow_o), 64'd1);
    chk("ovf.drain", 64'(rec_valid_o), 64'd0);

    // Reset while a record is held
    drive(1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'hD0, 2'd3, 1'b0);
    cycle();
    chk("rst2.full", 64'(rec_valid_o), 64'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rst2.valid", 64'(rec_valid_o), 64'd0);
    chk("rst2.overflow", 64'(overflow_o), 64'd0);
    chk("rst2.reg_cnt", 64'(rec_reg_cnt_o), 64'd0);
    @(negedge clk);
    rst_ni = 1'b1;

    // Reset while two events are pending
    drive(1'b1, 5'd3, 64'h33, 1'b0, 1'b1, 32'h100, 32'h55, 1'b0, 32'd0, 2'd0, 1'b1);
    cycle();
    drive(1'b0, 5'd0, 64'd0, 1'b1, 1'b0, 32'h200, 32'd0, 1'b0, 32'd0, 2'd0, 1'b1);
    cycle();
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rst3.valid", 64'(rec_valid_o), 64'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    drive(1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'hE0, 2'd0, 1'b1);
    cycle();
    chk_rec("rst3.rec", 32'd0, 32'd0, 32'd0, 32'hE0, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/cosim_commit_collector.md
Name: cosim_commit_collector

Overview:
- RTL-side producer of commit logs. It gathers the DUT's per-instruction register writes, memory reads and memory writes, then presents one commit record per retired instruction to the cosim checker.
- Record content matches what the spike side reports per step: reg-write list, mem-read list, mem-write list, pc, priv, proc_id, and a count for each list.
- Sits between the core's retirement/writeback taps and the cosim checker. It has one accumulation buffer and one output holding register.

Parameters:
- CommitLogEntries, 16: maximum items per list per instruction.
- ProcId, 0: value reported in rec_proc_id_o.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- ready_o  out  1  collector can accept events/retire this cycle
- reg_wr_valid_i  in  1  register write event
- reg_wr_item_i  in  $bits(commit_log_reg_item_t)  key+value (value zero-extended to FREG_W)
- mem_rd_valid_i  in  1  memory read event
- mem_rd_item_i  in  $bits(commit_log_mem_item_t)  addr/paddr/len (wdata=0)
- mem_wr_valid_i  in  1  memory write event
- mem_wr_item_i  in  $bits(commit_log_mem_item_t)  addr/paddr/wdata/len
- retire_valid_i  in  1  instruction retires; closes current record
- retire_pc_i  in  XREG_W  pc of retiring instruction
- retire_priv_i  in  2  privilege level at retire
- rec_valid_o  out  1  record available
- rec_ready_i  in  1  checker consumes record
- rec_pc_o  out  XREG_W  record pc
- rec_priv_o  out  32  record priv, zero-extended
- rec_proc_id_o  out  32  ProcId
- rec_reg_o  out  CommitLogEntries x reg item  reg-write list
- rec_reg_cnt_o  out  32  valid entries in rec_reg_o
- rec_mem_rd_o / rec_mem_rd_cnt_o  out  list / 32  mem-read list and count
- rec_mem_wr_o / rec_mem_wr_cnt_o  out  list / 32  mem-write list and count
- overflow_o  out  1  sticky: a list exceeded CommitLogEntries

Behaviour:
- Reset (async, rst_ni=0):
  - all counts 0; accumulation lists 0; rec_valid_o=0; rec_* data 0; overflow_o=0; ready_o=1 after release.
- Holding register has two states:
  - EMPTY: rec_valid_o=0.
  - FULL: rec_valid_o=1.
- Readiness:
  - ready_o = (state==EMPTY) | rec_ready_i.
  - ready_o is combinational from rec_ready_i; no path from *_valid_i to ready_o.
  - Inputs are sampled only when ready_o=1. When ready_o=0 the core must hold all event and retire inputs stable.
- Accumulation (on a ready cycle):
  - each valid event is appended at index cnt, then that list's cnt increments.
  - at most one event of each type per cycle.
- Retire (on a ready cycle):
  - the record includes events presented in the same cycle as retire_valid_i.
  - the accumulation lists plus same-cycle events are copied into the holding register; state becomes FULL next cycle.
  - accumulation counts clear to 0. List contents beyond count are don't-care but must read as 0 at reset.
- Event without retire: stays in accumulation and belongs to the next retiring instruction.
- Record handshake:
  - FULL & rec_ready_i & no retire -> EMPTY next cycle.
  - FULL & rec_ready_i & retire -> stays FULL with the new record (back-to-back, 1 record/cycle throughput).
  - Latency from retire to rec_valid_o is 1 cycle.
- Record data must not change while rec_valid_o=1 & !rec_ready_i.
- Overflow: an append when cnt==CommitLogEntries is dropped, count saturates at CommitLogEntries, and overflow_o sets. overflow_o clears only on reset.
- Retire with no events produces a record with all counts 0.
- Reset mid-record discards accumulation and the holding register; there is no partial record after reset.

Decomposition:
- Shared package cosim_pkg holds commit_log_reg_item_t, commit_log_mem_item_t, reg_key_t, reg_t, and CommitLogEntries.
- cosim_constants_pkg holds XREG_W, FREG_W, REG_KEY_* widths.
- Add to cosim_pkg: a commit_record_t packed struct (pc, priv, proc_id, three lists, three counts).
- One sub-module: cosim_log_list, a parameterised append-buffer (item type, depth, append, clear-on-retire, saturating count, overflow flag), instantiated three times.

Test Plan:
- Reset then idle: rec_valid_o=0, all counts 0, ready_o=1, overflow_o=0.
- ADDI: reg_wr(XREG id 5, value 0x2A) together with retire pc=0x80000000, priv=3 -> next cycle rec_valid_o=1, reg_cnt=1, rec_reg_o[0] key={5,XREG}, value 0x2A, mem counts 0, pc 0x80000000, priv 3.
- Store: mem_wr(addr 0x80001000, wdata 0xDEADBEEF, len 4) in cycle N, retire in N+1 -> one record with mem_wr_cnt=1 and matching fields; reg_cnt=0.
- Backpressure: retire A with rec_ready_i=0 -> record A held unchanged and ready_o=0 for 3 cycles; raise rec_ready_i with retire B -> A consumed, B presented the next cycle, no loss.
- Overflow: 17 reg writes then retire -> reg_cnt=16, entries 0..15 match the first 16 writes, overflow_o=1 and stays 1.
- Async reset asserted mid-accumulation (2 events pending, record FULL) -> immediately rec_valid_o=0; after release, a retire with no events yields all counts 0.
